// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with bounded memory waits, halt/step control
// and busy-cycle / retired-instruction counters.
module stage_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             sysclk,
  input  logic             cpu_reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             imem_ready,
  input  logic             mem_op,
  input  logic             dmem_ready,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             retire,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt,
    StError
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WaitW-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_instret;
  logic               w_waiting;
  logic               w_mem_done;

  assign w_mem_done = !mem_op || dmem_ready;

  always_comb begin
    w_state_next = r_state;
    w_waiting    = 1'b0;
    case (r_state)
      StIdle:    if (start) w_state_next = StFetch;
      StFetch: begin
        if (imem_ready) begin
          w_state_next = StDecode;
        end else begin
          w_waiting = 1'b1;
          if (r_wait_cnt == WaitMax) w_state_next = StError;
        end
      end
      StDecode:  w_state_next = StExecute;
      StExecute: w_state_next = StMem;
      StMem: begin
        // A ready arriving on the last allowed wait cycle still wins over the timeout.
        if (w_mem_done) begin
          w_state_next = StWb;
        end else begin
          w_waiting = 1'b1;
          if (r_wait_cnt == WaitMax) w_state_next = StError;
        end
      end
      StWb:      w_state_next = (halt_req || step_mode) ? StHalt : StFetch;
      StHalt:    if (start) w_state_next = StFetch;
      StError:   w_state_next = StError;
      default:   w_state_next = StError;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + WaitW'(1);
      end
      if (busy) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (r_state == StWb) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign f_en      = (r_state == StFetch) && imem_ready;
  assign d_en      = (r_state == StDecode);
  assign e_en      = (r_state == StExecute);
  assign m_en      = (r_state == StMem) && w_mem_done;
  assign w_en      = (r_state == StWb);
  assign retire    = (r_state == StWb);
  assign busy      = (r_state == StFetch) || (r_state == StDecode) || (r_state == StExecute) ||
                     (r_state == StMem) || (r_state == StWb);
  assign halted    = (r_state == StHalt);
  assign err       = (r_state == StError);
  assign cycle_cnt = r_cycle_cnt;
  assign instret   = r_instret;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed table-driven bench for stage_sequencer with small WAIT_MAX and CNT_W so
// timeout and counter wrap boundaries are reached quickly.
module tb_stage_sequencer;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned CNT_W    = 8;

  // {f,d,e,m,w,retire,busy,halted,err}
  localparam logic [8:0] E_IDLE = 9'b00000_0_0_0_0;
  localparam logic [8:0] E_F    = 9'b10000_0_1_0_0;
  localparam logic [8:0] E_D    = 9'b01000_0_1_0_0;
  localparam logic [8:0] E_E    = 9'b00100_0_1_0_0;
  localparam logic [8:0] E_M    = 9'b00010_0_1_0_0;
  localparam logic [8:0] E_W    = 9'b00001_1_1_0_0;
  localparam logic [8:0] E_BUSY = 9'b00000_0_1_0_0;
  localparam logic [8:0] E_H    = 9'b00000_0_0_1_0;
  localparam logic [8:0] E_ERR  = 9'b00000_0_0_0_1;

  logic             clk;
  logic             rst, start, hreq, step, imem, mop, dmem;
  logic             f_en, d_en, e_en, m_en, w_en, retire, busy, halted, err;
  logic [CNT_W-1:0] cycle_cnt, instret;
  logic [8:0]       obs;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic       rst, start, hreq, step, imem, mop, dmem;
    logic [8:0] exp;
    bit         chk;
    int         ecyc;
    int         eins;
  } vec_t;

  vec_t tbl[$];

  stage_sequencer #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W   (CNT_W)
  ) u_dut (
    .sysclk    (clk),
    .cpu_reset (rst),
    .start     (start),
    .halt_req  (hreq),
    .step_mode (step),
    .imem_ready(imem),
    .mem_op    (mop),
    .dmem_ready(dmem),
    .f_en      (f_en),
    .d_en      (d_en),
    .e_en      (e_en),
    .m_en      (m_en),
    .w_en      (w_en),
    .retire    (retire),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .cycle_cnt (cycle_cnt),
    .instret   (instret)
  );

  assign obs = {f_en, d_en, e_en, m_en, w_en, retire, busy, halted, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addc(input bit r, input bit s, input bit h, input bit st, input bit im,
                               input bit mo, input bit dm, input logic [8:0] e, input bit c,
                               input int ec, input int ei);
    vec_t v;
    v.rst = r; v.start = s; v.hreq = h; v.step = st; v.imem = im; v.mop = mo; v.dmem = dm;
    v.exp = e; v.chk = c; v.ecyc = ec; v.eins = ei;
    tbl.push_back(v);
  endfunction

  function automatic void add(input bit r, input bit s, input bit h, input bit st, input bit im,
                              input bit mo, input bit dm, input logic [8:0] e);
    addc(r, s, h, st, im, mo, dm, e, 1'b0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %0h required %0h", name, got, want);
    else pass_cnt++;
  endtask

  initial begin
    int nret, last_ret, bad_sp, bad_hot, not_busy;
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; start = 1'b0; hreq = 1'b0; step = 1'b0; imem = 1'b0; mop = 1'b0; dmem = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then four zero-wait instructions.
    addc(0, 0, 0, 0, 0, 0, 0, E_IDLE, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, E_IDLE);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 0, 0, 1, 0, 0, E_F);
      add(0, 0, 0, 0, 1, 0, 0, E_D);
      add(0, 0, 0, 0, 1, 0, 0, E_E);
      add(0, 0, 0, 0, 1, 0, 0, E_M);
      add(0, 0, 0, 0, 1, 0, 0, E_W);
    end
    // Three fetch wait cycles, halt_req raised from EXECUTE.
    addc(0, 0, 0, 0, 0, 0, 0, E_BUSY, 1, 20, 4);
    add(0, 0, 0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 1, 0, 0, E_F);
    add(0, 0, 0, 0, 1, 0, 0, E_D);
    add(0, 0, 1, 0, 1, 0, 0, E_E);
    add(0, 0, 1, 0, 1, 0, 0, E_M);
    add(0, 0, 1, 0, 1, 0, 0, E_W);
    addc(0, 0, 1, 0, 1, 0, 0, E_H, 1, 28, 5);
    add(0, 0, 1, 0, 1, 0, 0, E_H);
    add(0, 1, 0, 0, 1, 0, 0, E_H);
    // Step mode: one retire per start; start held while busy is ignored.
    add(0, 0, 0, 1, 1, 0, 0, E_F);
    add(0, 0, 0, 1, 1, 0, 0, E_D);
    add(0, 0, 0, 1, 1, 0, 0, E_E);
    add(0, 0, 0, 1, 1, 0, 0, E_M);
    add(0, 0, 0, 1, 1, 0, 0, E_W);
    addc(0, 0, 0, 1, 1, 0, 0, E_H, 1, 33, 6);
    add(0, 1, 0, 1, 1, 0, 0, E_H);
    add(0, 1, 0, 1, 1, 0, 0, E_F);
    add(0, 1, 0, 1, 1, 0, 0, E_D);
    add(0, 1, 0, 1, 1, 0, 0, E_E);
    add(0, 1, 0, 1, 1, 0, 0, E_M);
    add(0, 1, 0, 1, 1, 0, 0, E_W);
    addc(0, 0, 0, 1, 1, 0, 0, E_H, 1, 38, 7);
    add(0, 1, 0, 0, 1, 0, 0, E_H);
    // dmem_ready arrives exactly at wait_cnt == WAIT_MAX.
    add(0, 0, 0, 0, 1, 0, 0, E_F);
    add(0, 0, 0, 0, 1, 0, 0, E_D);
    add(0, 0, 0, 0, 1, 0, 0, E_E);
    for (int k = 0; k < WAIT_MAX; k++) add(0, 0, 0, 0, 1, 1, 0, E_BUSY);
    add(0, 0, 0, 0, 1, 1, 1, E_M);
    add(0, 0, 0, 0, 1, 1, 1, E_W);
    // WAIT_MAX+1 memory wait cycles time out into a sticky ERROR.
    addc(0, 0, 0, 0, 1, 0, 0, E_F, 1, 47, 8);
    add(0, 0, 0, 0, 1, 0, 0, E_D);
    add(0, 0, 0, 0, 1, 0, 0, E_E);
    for (int k = 0; k <= WAIT_MAX; k++) add(0, 0, 0, 0, 1, 1, 0, E_BUSY);
    addc(0, 0, 0, 0, 0, 1, 0, E_ERR, 1, 55, 8);
    add(0, 1, 0, 0, 0, 1, 0, E_ERR);
    add(0, 0, 0, 0, 1, 1, 1, E_ERR);
    add(1, 0, 0, 0, 0, 0, 0, E_ERR);
    addc(0, 0, 0, 0, 0, 0, 0, E_IDLE, 1, 0, 0);
    // Fetch timeout.
    add(0, 1, 0, 0, 0, 0, 0, E_IDLE);
    for (int k = 0; k <= WAIT_MAX; k++) add(0, 0, 0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 0, 0, 0, E_ERR);
    add(1, 0, 0, 0, 0, 0, 0, E_ERR);
    addc(0, 0, 0, 0, 0, 0, 0, E_IDLE, 1, 0, 0);
    // imem_ready at the fetch boundary, then reset during a memory wait.
    add(0, 1, 0, 0, 0, 0, 0, E_IDLE);
    for (int k = 0; k < WAIT_MAX; k++) add(0, 0, 0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 1, 0, 0, E_F);
    add(0, 0, 0, 0, 1, 0, 0, E_D);
    add(0, 0, 0, 0, 1, 0, 0, E_E);
    add(0, 0, 0, 0, 1, 1, 0, E_BUSY);
    add(1, 0, 0, 0, 1, 1, 0, E_BUSY);
    addc(0, 0, 0, 0, 1, 0, 0, E_IDLE, 1, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start; hreq = tbl[i].hreq; step = tbl[i].step;
      imem = tbl[i].imem; mop = tbl[i].mop; dmem = tbl[i].dmem;
      #1;
      check($sformatf("vec[%0d] outputs", i), 32'(obs), 32'(tbl[i].exp));
      if (tbl[i].chk) begin
        check($sformatf("vec[%0d] cycle_cnt", i), 32'(cycle_cnt), 32'(CNT_W'(tbl[i].ecyc)));
        check($sformatf("vec[%0d] instret", i), 32'(instret), 32'(CNT_W'(tbl[i].eins)));
      end
    end

    // Free run of 257 instructions: counters wrap, retires 5 cycles apart, one enable at a time.
    @(negedge clk);
    rst = 1'b0; start = 1'b1; hreq = 1'b0; step = 1'b0; imem = 1'b1; mop = 1'b0; dmem = 1'b0;
    @(negedge clk);
    start = 1'b0;
    nret = 0; last_ret = 0; bad_sp = 0; bad_hot = 0; not_busy = 0;
    for (int n = 0; n < 257 * 5; n++) begin
      #1;
      if (!busy) not_busy++;
      if ($countones({f_en, d_en, e_en, m_en, w_en}) != 1) bad_hot++;
      if (retire) begin
        if (nret > 0 && (n - last_ret) != 5) bad_sp++;
        last_ret = n;
        nret++;
      end
      @(negedge clk);
    end
    #1;
    check("wrap cycle_cnt", 32'(cycle_cnt), 32'd5);
    check("wrap instret", 32'(instret), 32'd1);
    check("run retire count", 32'(nret), 32'd257);
    check("run retire spacing errors", 32'(bad_sp), 32'd0);
    check("run enable one-hot errors", 32'(bad_hot), 32'd0);
    check("run non-busy cycles", 32'(not_busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
